// File: rtl/vga_fb_arbiter_if.sv
// Bundled display, host and RAM signals of the framebuffer arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface vga_fb_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_gnt;
  logic          disp_rvalid;
  logic [DW-1:0] disp_rdata;

  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  disp_req, disp_addr, host_req, host_we, host_addr, host_wdata, mem_rdata,
    output disp_gnt, disp_rvalid, disp_rdata, host_gnt, host_rvalid, host_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output disp_req, disp_addr, host_req, host_we, host_addr, host_wdata, mem_rdata,
    input  disp_gnt, disp_rvalid, disp_rdata, host_gnt, host_rvalid, host_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display-priority grant, registered RAM command,
// 2-cycle read return routing. Define FB_ARB_STARVE_GUARD_EN for the host starvation guard.
module vga_fb_arbiter #(
  parameter int AW            = 16,
  parameter int DW            = 8,
  parameter int HOST_WAIT_MAX = 15
) (
  input  logic               app_clk,
  input  logic               app_arst_n,
  vga_fb_arbiter_if.slave    bus
);

`ifdef FB_ARB_STARVE_GUARD_EN
  localparam bit GuardEn = 1'b1;
`else
  localparam bit GuardEn = 1'b0;
`endif
  localparam logic [7:0] WaitMax = 8'(HOST_WAIT_MAX);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic          force_host;
  logic          disp_gnt;
  logic          host_gnt;
  logic          rd_issue;
  logic [7:0]    wait_q, wait_d;

  logic          mem_en_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;

  logic          vld_p1_q, own_p1_q;
  logic          vld_p2_q, own_p2_q;
  logic          disp_rvalid, host_rvalid;
  logic [DW-1:0] disp_rdata, host_rdata;
  logic [DW-1:0] disp_rdata_q, host_rdata_q;

  always_comb begin
    force_host = GuardEn && bus.host_req && (wait_q == WaitMax);
    disp_gnt   = app_arst_n && bus.disp_req && !force_host;
    host_gnt   = app_arst_n && bus.host_req && (!bus.disp_req || force_host);
    rd_issue   = disp_gnt || (host_gnt && !bus.host_we);
    wait_d     = (!bus.host_req || host_gnt) ? 8'd0 : sat_inc8(wait_q);
  end

  // own_pN = 1 marks a host read; stage 2 lines up with mem_rdata
  always_comb begin
    disp_rvalid = vld_p2_q && !own_p2_q;
    host_rvalid = vld_p2_q && own_p2_q;
    disp_rdata  = disp_rvalid ? bus.mem_rdata : disp_rdata_q;
    host_rdata  = host_rvalid ? bus.mem_rdata : host_rdata_q;
  end

  always_ff @(posedge app_clk) begin
    if (!app_arst_n) begin
      wait_q       <= 8'd0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      vld_p1_q     <= 1'b0;
      own_p1_q     <= 1'b0;
      vld_p2_q     <= 1'b0;
      own_p2_q     <= 1'b0;
      disp_rdata_q <= '0;
      host_rdata_q <= '0;
    end else begin
      wait_q   <= wait_d;
      mem_en_q <= disp_gnt || host_gnt;
      mem_we_q <= host_gnt && bus.host_we;
      if (disp_gnt) begin
        mem_addr_q <= bus.disp_addr;
      end else if (host_gnt) begin
        mem_addr_q  <= bus.host_addr;
        mem_wdata_q <= bus.host_wdata;
      end
      // stage 1: command on the RAM pins
      vld_p1_q     <= rd_issue;
      own_p1_q     <= host_gnt;
      // stage 2: read data returning
      vld_p2_q     <= vld_p1_q;
      own_p2_q     <= own_p1_q;
      disp_rdata_q <= disp_rdata;
      host_rdata_q <= host_rdata;
    end
  end

  assign bus.disp_gnt    = disp_gnt;
  assign bus.host_gnt    = host_gnt;
  assign bus.disp_rvalid = disp_rvalid;
  assign bus.host_rvalid = host_rvalid;
  assign bus.disp_rdata  = disp_rdata;
  assign bus.host_rdata  = host_rdata;
  assign bus.mem_en      = mem_en_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Arbitrates a single-port framebuffer RAM between two requesters: the VGA scanout fetcher (display port) and a host writer/reader (host port). It sits between `vga_sync`'s pixel fetch logic and the pixel RAM, and runs on `app_clk25`. The display port always wins contention; an optional starvation guard forces the host through after a bounded wait. The RAM command path is registered, and read data returns with a fixed latency to the port that issued the read.

## Interface

- `AW`, 16: framebuffer word address width.
- `DW`, 8: data width; one pixel in RRRGGGBB format.
- `HOST_WAIT_MAX`, 15: consecutive host-stalled cycles before a forced host grant (guard build only); legal range 1..255.

- `app_clk` in 1: clock; `app_clk25` at the top level.
- `app_arst_n` in 1: reset; synchronous, active-low.
- `disp_req` in 1: display read request.
- `disp_addr` in AW: display read address.
- `disp_gnt` out 1: display request accepted this cycle.
- `disp_rvalid` out 1: `disp_rdata` valid.
- `disp_rdata` out DW: display read data.
- `host_req` in 1: host request.
- `host_we` in 1: 1 = write, 0 = read.
- `host_addr` in AW: host address.
- `host_wdata` in DW: host write data.
- `host_gnt` out 1: host request accepted this cycle.
- `host_rvalid` out 1: `host_rdata` valid.
- `host_rdata` out DW: host read data.
- `mem_en` out 1: RAM access strobe.
- `mem_we` out 1: RAM write enable.
- `mem_addr` out AW: RAM address.
- `mem_wdata` out DW: RAM write data.
- `mem_rdata` in DW: RAM read data, valid one cycle after `mem_en` with `mem_we` = 0.

## Operation

- **Handshake.**
  - A requester holds `*_req` and its address/data stable until it sees `*_gnt` high on a rising edge.
  - A grant consumes the request on that edge.
  - `*_gnt` is combinational from the `*_req` inputs and the arbiter state.
- **Arbitration, evaluated every cycle:**
  - disp_req only: display granted.
  - host_req only: host granted.
  - Both high: display granted, unless a forced host grant is due (Configuration). Never both grants in one cycle.
- **Command register.**
  - On a grant, the arbiter loads `mem_en`, `mem_we`, `mem_addr` and `mem_wdata` from the winner on the next edge.
  - With no grant, `mem_en` = 0 and `mem_we` = 0; address and data hold their last values.
  - A display grant always loads `mem_we` = 0.
- **Read return tracking.**
  - A 2-stage owner pipe records a read valid bit and its owner (disp/host) for each issued read.
  - At stage 2, the arbiter pulses the owner's `*_rvalid` for 1 cycle and drives that owner's `*_rdata` from `mem_rdata`.
  - The non-owner's `*_rdata` holds its last value.
  - Writes produce no `rvalid`.
- **Wait counter.**
  - 8 bits; increments, saturating at 255, on each cycle with host_req = 1 and host_gnt = 0.
  - Clears on a host grant or when host_req = 0.

## Timing

- Request and grant in cycle N. `mem_*` valid in N+1. `mem_rdata` sampled in N+2. `*_rvalid` and `*_rdata` valid in N+2.
- Throughput is one access per cycle, sustained. Back-to-back grants to alternating owners return data in issue order.
- **Reset (app_arst_n = 0 at an edge):**
  - All gnt, rvalid, `mem_en` and `mem_we` are 0.
  - `mem_addr`, `mem_wdata` and both rdata are 0.
  - Owner pipe and wait counter are cleared.
  - Reads in flight when reset asserts are dropped; no `rvalid` follows reset.
  - Grants are combinationally 0 while reset is low.
- Simultaneous host write and display read: the display read is issued first. The host write issues on the first cycle disp_req = 0, or on a forced grant.

## Configuration

- **`FB_ARB_STARVE_GUARD_EN` defined:**
  - When the wait counter equals HOST_WAIT_MAX, the host is granted on that cycle, even if disp_req = 1.
  - disp_gnt = 0 that cycle; the display requester retries on the next cycle.
  - The counter then clears.
  - Worst-case host wait is HOST_WAIT_MAX + 1 cycles.
- **Undefined:**
  - Strict display priority; the host can starve indefinitely.
  - The wait counter is still present but has no effect on arbitration.
  - HOST_WAIT_MAX is ignored.

## Test plan

- Reset held 3 cycles with both reqs high: all outputs 0, no grants. Release reset: disp_gnt = 1 on the first cycle after release.
- Host write addr 0x0010 data 0xE3 with no display traffic, then host read 0x0010: host_gnt same cycle each time. On the write, `mem_en`/`mem_we` = 1/1 next cycle. On the read, host_rvalid = 1 with host_rdata = 0xE3 two cycles after its grant.
- Display reads addr 0..7 on consecutive cycles: 8 display grants, 8 disp_rvalid pulses starting 2 cycles after the first grant, data in order, host_rvalid never set.
- Alternating disp/host reads interleaved cycle by cycle: each rvalid arrives at the correct owner exactly 2 cycles after its grant, with no cross-routing.
- Guard build, HOST_WAIT_MAX = 15, disp_req and host_req held high: host_gnt = 1 on the 16th cycle and disp_gnt = 0 that cycle. Repeats every 16 cycles. Non-guard build: host_gnt never asserts.
- App_arst_n pulsed low one cycle after a display read is granted: no disp_rvalid for that read, and the counters are cleared.
